// File: rtl/ctrl_decode_stage_pkg.sv
// Shared RV32I/M decode constants and the registered control bundle type.
// Used by the decoder and the stage register; purely declarative.
package ctrl_decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_RV32M = 7'b0000001;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] WB_ALU    = 3'b000;
  localparam logic [2:0] WB_MEM    = 3'b001;
  localparam logic [2:0] WB_PC4    = 3'b010;
  localparam logic [2:0] WB_IMM    = 3'b011;
  localparam logic [2:0] WB_PC_IMM = 3'b100;
  localparam logic [2:0] WB_MD     = 3'b101;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       bu_jb;
    logic       mem_we;
    logic       rf_we;
    logic [2:0] imm_src;
    logic [2:0] wb_src;
    logic [3:0] alu_ctrl;
    logic       md_op;
    logic [2:0] md_funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ctrl_bundle_t;

  // alt selects SUB/SRA; callers only raise it where those encodings are legal
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// Handshake, stall/flush and registered control bundle of the decode stage.
// The stage itself uses the slave view; the instruction source/EX side uses master.
interface ctrl_decode_stage_if #(
  parameter int ALU_CTRL_W = 4
);
  logic                  i_valid;
  logic                  o_ready;
  logic [31:0]           i_instr;
  logic                  i_stall;
  logic                  i_flush;
  logic                  o_valid;
  logic                  o_alu_op_src_ctrl;
  logic                  o_branch;
  logic                  o_jump;
  logic                  o_bu_jb_ctrl;
  logic                  o_mem_we;
  logic                  o_rf_we_ctrl;
  logic [2:0]            o_sx_imm_src_ctrl;
  logic [2:0]            o_rf_wb_scr_ctrl;
  logic [ALU_CTRL_W-1:0] o_alu_ctrl;
  logic                  o_md_op;
  logic [2:0]            o_md_funct3;
  logic [4:0]            o_rd;
  logic [4:0]            o_rs1;
  logic [4:0]            o_rs2;
  logic                  o_illegal;
  logic                  o_md_busy;

  modport master (
    output i_valid, i_instr, i_stall, i_flush,
    input  o_ready, o_valid, o_alu_op_src_ctrl, o_branch, o_jump, o_bu_jb_ctrl,
           o_mem_we, o_rf_we_ctrl, o_sx_imm_src_ctrl, o_rf_wb_scr_ctrl, o_alu_ctrl,
           o_md_op, o_md_funct3, o_rd, o_rs1, o_rs2, o_illegal, o_md_busy
  );

  modport slave (
    input  i_valid, i_instr, i_stall, i_flush,
    output o_ready, o_valid, o_alu_op_src_ctrl, o_branch, o_jump, o_bu_jb_ctrl,
           o_mem_we, o_rf_we_ctrl, o_sx_imm_src_ctrl, o_rf_wb_scr_ctrl, o_alu_ctrl,
           o_md_op, o_md_funct3, o_rd, o_rs1, o_rs2, o_illegal, o_md_busy
  );

endinterface

// File: rtl/ctrl_decode_stage_rv_decode_comb.sv
// Combinational RV32I instruction -> control bundle decode with illegal detection.
// RV32M_EN adds the funct7=0000001 multiply/divide group; otherwise it is illegal.
module rv_decode_comb
  import ctrl_decode_stage_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t bundle
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    bundle  = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI: begin
        bundle.rf_we   = 1'b1;
        bundle.alu_src = 1'b1;
        bundle.imm_src = IMM_U;
        bundle.wb_src  = WB_IMM;
      end
      OPC_AUIPC: begin
        bundle.rf_we   = 1'b1;
        bundle.alu_src = 1'b1;
        bundle.imm_src = IMM_U;
        bundle.wb_src  = WB_PC_IMM;
      end
      OPC_JAL: begin
        bundle.rf_we   = 1'b1;
        bundle.imm_src = IMM_J;
        bundle.wb_src  = WB_PC4;
        bundle.branch  = 1'b1;
        bundle.jump    = 1'b1;
        bundle.bu_jb   = 1'b1;
      end
      OPC_JALR: begin
        bundle.rf_we   = 1'b1;
        bundle.alu_src = 1'b1;
        bundle.imm_src = IMM_I;
        bundle.wb_src  = WB_PC4;
        bundle.jump    = 1'b1;
      end
      OPC_BRANCH: begin
        bundle.branch   = 1'b1;
        bundle.imm_src  = IMM_B;
        bundle.alu_ctrl = ALU_SUB;
      end
      OPC_LOAD: begin
        bundle.rf_we   = 1'b1;
        bundle.alu_src = 1'b1;
        bundle.imm_src = IMM_I;
        bundle.wb_src  = WB_MEM;
      end
      OPC_STORE: begin
        bundle.mem_we  = 1'b1;
        bundle.alu_src = 1'b1;
        bundle.imm_src = IMM_S;
      end
      OPC_OP_IMM: begin
        bundle.rf_we    = 1'b1;
        bundle.alu_src  = 1'b1;
        bundle.imm_src  = IMM_I;
        // funct7 is immediate data except on shifts, so ADDI can never become SUB
        bundle.alu_ctrl = alu_from_funct3(funct3, funct7[5] && (funct3 == F3_SR));
        if (funct3 == F3_SLL && funct7 != F7_BASE)
          illegal = 1'b1;
        if (funct3 == F3_SR && funct7 != F7_BASE && funct7 != F7_ALT)
          illegal = 1'b1;
      end
      OPC_OP: begin
        bundle.rf_we = 1'b1;
        if (funct7 == F7_BASE)
          bundle.alu_ctrl = alu_from_funct3(funct3, 1'b0);
        else if (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SR))
          bundle.alu_ctrl = alu_from_funct3(funct3, 1'b1);
`ifdef RV32M_EN
        else if (funct7 == F7_RV32M) begin
          bundle.md_op     = 1'b1;
          bundle.md_funct3 = funct3;
          bundle.wb_src    = WB_MD;
        end
`endif
        else
          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    // An illegal instruction must not write or redirect anything downstream
    if (illegal) begin
      bundle         = '0;
      bundle.illegal = 1'b1;
    end
    bundle.rd  = instr[11:7];
    bundle.rs1 = instr[19:15];
    bundle.rs2 = instr[24:20];
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage: bundle visible one cycle after accept; stall holds, flush bubbles.
// RV32M_EN enables the M-op busy FSM (o_ready low for MD_LATENCY-1 cycles after an M-op accept).
module ctrl_decode_stage
  import ctrl_decode_stage_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int ALU_CTRL_W = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  ctrl_decode_stage_if.slave bus
);

  ctrl_bundle_t dec_bundle;
  ctrl_bundle_t out_q;
  logic         out_vld_q;
  logic         run;
  logic         xfer;

  rv_decode_comb u_decode (
    .instr  (bus.i_instr),
    .bundle (dec_bundle)
  );

`ifdef RV32M_EN
  localparam int CNT_LOAD = (MD_LATENCY > 1) ? MD_LATENCY - 2 : 0;

  md_state_e  state_q;
  md_state_e  state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (xfer && dec_bundle.md_op && (MD_LATENCY > 1)) begin
          state_d = MD_BUSY;
          cnt_d   = 4'(CNT_LOAD);
        end
      end
      MD_BUSY: begin
        if (bus.i_flush || cnt_q == 4'd0) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign run           = (state_q == RUN);
  assign bus.o_md_busy = (state_q == MD_BUSY);
`else
  assign run           = 1'b1;
  assign bus.o_md_busy = 1'b0;
`endif

  // Reset is folded in so nothing is offered as accepted while the core is held
  assign bus.o_ready = run && !bus.i_stall && !bus.i_flush && !i_rst;
  assign xfer        = bus.i_valid && bus.o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (bus.i_flush) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (!bus.i_stall) begin
      if (xfer) begin
        out_vld_q <= 1'b1;
        out_q     <= dec_bundle;
      end else begin
        out_vld_q <= 1'b0;
        out_q     <= '0;
      end
    end
  end

  assign bus.o_valid           = out_vld_q;
  assign bus.o_alu_op_src_ctrl = out_q.alu_src;
  assign bus.o_branch          = out_q.branch;
  assign bus.o_jump            = out_q.jump;
  assign bus.o_bu_jb_ctrl      = out_q.bu_jb;
  assign bus.o_mem_we          = out_q.mem_we;
  assign bus.o_rf_we_ctrl      = out_q.rf_we;
  assign bus.o_sx_imm_src_ctrl = out_q.imm_src;
  assign bus.o_rf_wb_scr_ctrl  = out_q.wb_src;
  assign bus.o_alu_ctrl        = ALU_CTRL_W'(out_q.alu_ctrl);
  assign bus.o_md_op           = out_q.md_op;
  assign bus.o_md_funct3       = out_q.md_funct3;
  assign bus.o_rd              = out_q.rd;
  assign bus.o_rs1             = out_q.rs1;
  assign bus.o_rs2             = out_q.rs2;
  assign bus.o_illegal         = out_q.illegal;

endmodule
